io_pi_array: RTL and testbench
==============================

# io_pi_array

Parametrised multi-channel programmable input-pad tile that succeeds the single-channel input pad. It takes `NUM_CH` pad inputs from the GPIN boundary and conditions each one for the fabric. Per channel, the tile can disable the input, bypass it, synchronise it, or synchronise and glitch-filter it, with optional inversion and a one-cycle change-event pulse. Per-channel configuration lives in a scan chain that is shifted through `sc_in`/`sc_out`. The tile sits in the IO ring between the pads and the routing fabric.

## Interface
Parameters:
- `NUM_CH`, default 8: number of pad channels, 1..64.
- `FILT_CYCLES`, default 4: consecutive stable cycles required by the glitch filter, 1..255.

Ports:
- `io_pi_array_clk`, input, 1: tile clock.
- `io_pi_array_reset`, input, 1: asynchronous, active-low reset.
- `io_pi_array_se`, input, 1: scan enable; 1 shifts the configuration chain.
- `io_pi_array_sc_in`, input, 1: scan chain serial input.
- `io_pi_array_sc_out`, output, 1: scan chain serial output.
- `gfpga_pad_pinput_A2F`, input, `NUM_CH`: raw pad inputs, asynchronous to the clock.
- `gfpga_pad_pinput_mode_o`, output, `NUM_CH`: pad direction control; constant 1 = input.
- `io_pi_array_a2f_o`, output, `NUM_CH`: conditioned data to the fabric.
- `io_pi_array_edge_o`, output, `NUM_CH`: one-cycle pulse when the channel's registered output changes.

## Operation
- Configuration per channel is 3 bits `{inv, mode[1:0]}`, giving a chain length of 3*`NUM_CH`.
- Chain order: `sc_in` feeds channel 0 `mode[0]`, then `mode[1]`, then `inv`, then channel 1, and so on. `sc_out` is channel `NUM_CH`-1 `inv`.
- Shift: on each rising clock edge with `se`=1, every chain bit moves one position. With `se`=0 the chain holds.
- Modes:
  - 00 OFF: `a2f_o`=0 and `edge_o`=0.
  - 01 BYPASS: `a2f_o` = pad XOR `inv`, combinational. `edge_o`=0.
  - 10 SYNC: two-flop synchroniser. `a2f_o` = sync2 XOR `inv`.
  - 11 FILT: synchroniser followed by a stability counter. The filtered state takes the new synchronised value only after it differs from the current state for `FILT_CYCLES` consecutive cycles. Any return to the current value clears the counter to 0.
- The counter width is clog2(`FILT_CYCLES`+1) and the counter saturates; it never wraps.
- `edge_o` is asserted for one cycle whenever the pre-inversion registered output (sync2 in SYNC, filtered state in FILT) differs from its value on the previous cycle.
- While `se`=1: synchronisers keep running, but the filter counter and filtered state freeze, and `edge_o` is forced to 0. `a2f_o` keeps its pre-shift value for every registered channel.
- Config change mid-operation (`se` falls): the filtered state reloads from sync2 with no edge pulse. The counter clears. The new mode takes effect on the next cycle.
- Reset (asynchronous, during any activity): all config bits, synchronisers, counters and filtered states clear to 0. Every channel is then OFF, so `a2f_o`=0, `edge_o`=0 and `sc_out`=0.
- `mode_o` is all-ones, including during reset.

## Timing
- BYPASS latency: 0 cycles, combinational.
- SYNC latency: a pad change that meets setup before edge k appears on `a2f_o` after edge k+1 (2 edges).
- FILT latency: 2 + `FILT_CYCLES` edges from the pad change to `a2f_o`. A pulse shorter than `FILT_CYCLES` cycles never propagates.
- `edge_o` is registered and aligned with the cycle in which `a2f_o` changes.
- Scan: bit b written at `sc_in` appears on `sc_out` after 3*`NUM_CH` shift edges.
- Reset deassertion is synchronised internally: two-flop reset synchroniser, async assert, sync release.

## Structure
- Package `io_pi_pkg` holds:
  - the `io_pi_mode_e` enum (OFF, BYPASS, SYNC, FILT);
  - `IO_PI_CFG_BITS`=3;
  - the `io_pi_cfg_t` struct `{inv, mode}`.
- Sub-module `io_pi_chan`: one channel, containing the synchroniser, filter, edge detect and output mux. The top level instantiates it `NUM_CH` times.
- The scan chain register and the reset synchroniser live at the top level.

## Test plan
- Reset, then shift 3*`NUM_CH` ones with `se`=1 → `sc_out` rises exactly at shift 3*`NUM_CH`. All `a2f_o`=0 until `se` falls. After that, all channels are FILT with inverted output, so with pads at 0, `a2f_o`=all-ones after the filter settles.
- Channel 0 SYNC, `inv`=0, pad 0→1 → `a2f_o[0]`=1 two edges later, and `edge_o[0]` pulses once in that same cycle.
- Channel 1 FILT, `FILT_CYCLES`=4: 3-cycle high pulse → no change on `a2f_o[1]`. 5-cycle high pulse → `a2f_o[1]` rises 6 edges after the pad rises.
- Channel 2 BYPASS, `inv`=1: toggle the pad → `a2f_o[2]` is the same-cycle complement, and `edge_o[2]` stays 0.
- Pull reset low during a shift and mid-filter count → all outputs 0 immediately. After release, the chain reads back all-zeros and `mode_o` stays all-ones throughout.
- Assert `se` while a FILT channel is counting → `a2f_o` is held and `edge_o`=0. On release, no spurious edge pulse.

Source files
------------

// File: rtl/io_pi_pkg.sv
// Shared types for the programmable input-pad tile.
package io_pi_pkg;

  // Configuration bits per channel: {inv, mode[1:0]}
  localparam int unsigned IO_PI_CFG_BITS = 3;

  typedef enum logic [1:0] {
    ModeOff    = 2'b00,
    ModeBypass = 2'b01,
    ModeSync   = 2'b10,
    ModeFilt   = 2'b11
  } io_pi_mode_e;

  typedef struct packed {
    logic        inv;
    io_pi_mode_e mode;
  } io_pi_cfg_t;

  // Modes whose output comes from a flop rather than straight from the pad
  function automatic logic io_pi_is_registered(io_pi_mode_e mode);
    return (mode == ModeSync) || (mode == ModeFilt);
  endfunction

endpackage

// File: rtl/io_pi_chan.sv
// One input-pad channel: synchroniser, glitch filter, edge detect and output mux.
module io_pi_chan
  import io_pi_pkg::*;
#(
  parameter int unsigned FiltCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       se_i,      // chain is shifting: freeze filter, hold output
  input  logic       reload_i,  // first cycle after a shift: adopt new config
  input  io_pi_cfg_t cfg_i,     // this channel's slice of the scan chain
  input  logic       pad_i,
  output logic       a2f_o,
  output logic       edge_o
);

  localparam int unsigned CntW = $clog2(FiltCycles + 1);
  // Commit happens on the cycle the counter would reach FiltCycles
  localparam logic [CntW-1:0] CntLast = CntW'(FiltCycles - 1);

  io_pi_cfg_t      cfg_q;
  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold_q;
  logic            edge_q, edge_d;
  logic            is_reg;
  logic            hold_active;
  logic            src_q, src_d;

  assign is_reg      = io_pi_is_registered(cfg_q.mode);
  assign hold_active = se_i | reload_i;

  // Current and next value of the pre-inversion registered output
  assign src_q = (cfg_q.mode == ModeFilt) ? filt_q : sync2_q;
  assign src_d = (cfg_q.mode == ModeFilt) ? filt_d : sync1_q;

  // Active config only follows the chain while it is not shifting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else if (!se_i) begin
      cfg_q <= cfg_i;
    end
  end

  // Two-flop synchroniser; keeps running during shift
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Stability filter next state: frozen during shift, reloaded after it
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (se_i) begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
    end else if (reload_i) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Filter state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Registered edge: flags the cycle in which the registered output will differ
  always_comb begin
    edge_d = is_reg && !se_i && !reload_i && (src_d != src_q);
  end

  // Edge flop and the value shown while the chain is shifting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      edge_q <= edge_d;
      if (!hold_active) begin
        hold_q <= src_q;
      end
    end
  end

  assign edge_o = edge_q & ~se_i;

  // Output mux per mode
  always_comb begin
    a2f_o = 1'b0;
    unique case (cfg_q.mode)
      ModeOff:            a2f_o = 1'b0;
      ModeBypass:         a2f_o = pad_i ^ cfg_q.inv;
      ModeSync, ModeFilt: a2f_o = (hold_active ? hold_q : src_q) ^ cfg_q.inv;
      default:            a2f_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/io_pi_array.sv
// Multi-channel programmable input-pad tile with scan-loaded configuration.
module io_pi_array
  import io_pi_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic              io_pi_array_clk,
  input  logic              io_pi_array_reset,
  input  logic              io_pi_array_se,
  input  logic              io_pi_array_sc_in,
  output logic              io_pi_array_sc_out,
  input  logic [NUM_CH-1:0] gfpga_pad_pinput_A2F,
  output logic [NUM_CH-1:0] gfpga_pad_pinput_mode_o,
  output logic [NUM_CH-1:0] io_pi_array_a2f_o,
  output logic [NUM_CH-1:0] io_pi_array_edge_o
);

  localparam int unsigned ChainLen = IO_PI_CFG_BITS * NUM_CH;

  logic [1:0]          rst_sync_q;
  logic                rst_n_int;
  logic [ChainLen-1:0] chain_q;
  logic                se_q;
  logic                reload;
  io_pi_cfg_t          chan_cfg [NUM_CH];

  // Reset synchroniser: asserts immediately, releases after two edges
  always_ff @(posedge io_pi_array_clk or negedge io_pi_array_reset) begin
    if (!io_pi_array_reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // Configuration scan chain; bit 0 is fed from sc_in
  always_ff @(posedge io_pi_array_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      chain_q <= '0;
    end else if (io_pi_array_se) begin
      chain_q <= {chain_q[ChainLen-2:0], io_pi_array_sc_in};
    end
  end

  // Previous scan enable, used to spot the end of a shift
  always_ff @(posedge io_pi_array_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      se_q <= 1'b0;
    end else begin
      se_q <= io_pi_array_se;
    end
  end

  assign reload             = se_q & ~io_pi_array_se;
  assign io_pi_array_sc_out = chain_q[ChainLen-1];

  // Pads are input-only
  assign gfpga_pad_pinput_mode_o = '1;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_chan
    assign chan_cfg[g] = io_pi_cfg_t'(chain_q[g*IO_PI_CFG_BITS +: IO_PI_CFG_BITS]);

    io_pi_chan #(
      .FiltCycles (FILT_CYCLES)
    ) u_chan (
      .clk_i    (io_pi_array_clk),
      .rst_ni   (rst_n_int),
      .se_i     (io_pi_array_se),
      .reload_i (reload),
      .cfg_i    (chan_cfg[g]),
      .pad_i    (gfpga_pad_pinput_A2F[g]),
      .a2f_o    (io_pi_array_a2f_o[g]),
      .edge_o   (io_pi_array_edge_o[g])
    );
  end

endmodule

// File: tb/tb_io_pi_array.sv
// Directed self-checking bench for io_pi_array (4 channels, 4-cycle filter).
module tb_io_pi_array;

  localparam int unsigned NCh      = 4;
  localparam int unsigned Filt     = 4;
  localparam int unsigned ChainLen = 3 * NCh;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           se = 1'b0;
  logic           sc_in = 1'b0;
  logic           sc_out;
  logic [NCh-1:0] pad = '0;
  logic [NCh-1:0] mode_o;
  logic [NCh-1:0] a2f;
  logic [NCh-1:0] edge_s;

  int n_cmp = 0;
  int n_fail = 0;

  // ch3 OFF, ch2 BYPASS inv, ch1 FILT, ch0 SYNC
  logic [ChainLen-1:0] cfg_mix = 12'h15A;

  io_pi_array #(
    .NUM_CH      (NCh),
    .FILT_CYCLES (Filt)
  ) dut (
    .io_pi_array_clk         (clk),
    .io_pi_array_reset       (rst_n),
    .io_pi_array_se          (se),
    .io_pi_array_sc_in       (sc_in),
    .io_pi_array_sc_out      (sc_out),
    .gfpga_pad_pinput_A2F    (pad),
    .gfpga_pad_pinput_mode_o (mode_o),
    .io_pi_array_a2f_o       (a2f),
    .io_pi_array_edge_o      (edge_s)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_cfg(input logic [ChainLen-1:0] v);
    se = 1'b1;
    for (int i = ChainLen - 1; i >= 0; i--) begin
      sc_in = v[i];
      step();
    end
    se = 1'b0;
    sc_in = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (a2f !== 4'b0000) begin n_fail++; $display("FAIL reset_a2f: got %b want 0000", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL reset_edge: got %b want 0000", edge_s); end
    n_cmp++; if (sc_out !== 1'b0) begin n_fail++; $display("FAIL reset_sc_out: got %b want 0", sc_out); end
    n_cmp++; if (mode_o !== 4'b1111) begin n_fail++; $display("FAIL reset_mode_o: got %b want 1111", mode_o); end
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++; if (a2f !== 4'b0000) begin n_fail++; $display("FAIL post_reset_a2f: got %b want 0000", a2f); end
    n_cmp++; if (mode_o !== 4'b1111) begin n_fail++; $display("FAIL post_reset_mode_o: got %b want 1111", mode_o); end
  endtask

  task automatic test_scan_ones();
    se = 1'b1;
    sc_in = 1'b1;
    for (int s = 1; s <= ChainLen; s++) begin
      step();
      n_cmp++;
      if (sc_out !== (s == ChainLen)) begin
        n_fail++; $display("FAIL scan_sc_out shift %0d: got %b want %b", s, sc_out, s == ChainLen);
      end
      n_cmp++; if (a2f !== 4'b0000) begin n_fail++; $display("FAIL scan_a2f shift %0d: got %b want 0000", s, a2f); end
    end
    se = 1'b0;
    sc_in = 1'b0;
    n_cmp++; if (a2f !== 4'b0000) begin n_fail++; $display("FAIL scan_fall_a2f: got %b want 0000", a2f); end
    step();
    n_cmp++; if (a2f !== 4'b1111) begin n_fail++; $display("FAIL filt_inv_a2f: got %b want 1111", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL filt_inv_edge: got %b want 0000", edge_s); end
    repeat (3) step();
    n_cmp++; if (a2f !== 4'b1111) begin n_fail++; $display("FAIL filt_inv_settled: got %b want 1111", a2f); end
  endtask

  task automatic test_sync();
    shift_cfg(cfg_mix);
    step();
    n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL mix_cfg_a2f: got %b want 0100", a2f); end
    pad[0] = 1'b1;
    step();
    n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL sync_edge1_a2f: got %b want 0100", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL sync_edge1_edge: got %b want 0000", edge_s); end
    step();
    n_cmp++; if (a2f !== 4'b0101) begin n_fail++; $display("FAIL sync_rise_a2f: got %b want 0101", a2f); end
    n_cmp++; if (edge_s !== 4'b0001) begin n_fail++; $display("FAIL sync_rise_edge: got %b want 0001", edge_s); end
    step();
    n_cmp++; if (a2f !== 4'b0101) begin n_fail++; $display("FAIL sync_hold_a2f: got %b want 0101", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL sync_pulse_once: got %b want 0000", edge_s); end
    pad[0] = 1'b0;
    step();
    step();
    n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL sync_fall_a2f: got %b want 0100", a2f); end
    n_cmp++; if (edge_s !== 4'b0001) begin n_fail++; $display("FAIL sync_fall_edge: got %b want 0001", edge_s); end
    step();
  endtask

  task automatic test_filter();
    logic [NCh-1:0] exp_a2f;
    logic [NCh-1:0] exp_edge;
    // 3-cycle pulse must be swallowed
    pad[1] = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      step();
      if (s == 3) pad[1] = 1'b0;
      n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL filt_short_a2f step %0d: got %b want 0100", s, a2f); end
      n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL filt_short_edge step %0d: got %b want 0000", s, edge_s); end
    end
    // 5-cycle pulse passes: rises 6 edges after pad, falls 6 edges after pad falls
    pad[1] = 1'b1;
    for (int s = 1; s <= 13; s++) begin
      step();
      if (s == 5) pad[1] = 1'b0;
      exp_a2f  = {1'b0, 1'b1, (s >= 6 && s <= 10), 1'b0};
      exp_edge = {2'b00, (s == 6 || s == 11), 1'b0};
      n_cmp++; if (a2f !== exp_a2f) begin n_fail++; $display("FAIL filt_long_a2f step %0d: got %b want %b", s, a2f, exp_a2f); end
      n_cmp++; if (edge_s !== exp_edge) begin n_fail++; $display("FAIL filt_long_edge step %0d: got %b want %b", s, edge_s, exp_edge); end
    end
  endtask

  task automatic test_bypass();
    pad[2] = 1'b1;
    #1;
    n_cmp++; if (a2f[2] !== 1'b0) begin n_fail++; $display("FAIL bypass_hi: got %b want 0", a2f[2]); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL bypass_edge_hi: got %b want 0000", edge_s); end
    pad[2] = 1'b0;
    #1;
    n_cmp++; if (a2f[2] !== 1'b1) begin n_fail++; $display("FAIL bypass_lo: got %b want 1", a2f[2]); end
    pad[2] = 1'b1;
    step();
    n_cmp++; if (a2f[2] !== 1'b0) begin n_fail++; $display("FAIL bypass_clk_hi: got %b want 0", a2f[2]); end
    n_cmp++; if (edge_s[2] !== 1'b0) begin n_fail++; $display("FAIL bypass_clk_edge: got %b want 0", edge_s[2]); end
    pad[2] = 1'b0;
    #1;
    n_cmp++; if (a2f[2] !== 1'b1) begin n_fail++; $display("FAIL bypass_lo2: got %b want 1", a2f[2]); end
    step();
  endtask

  task automatic test_se_hold();
    pad[1] = 1'b1;
    repeat (3) step();
    n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL hold_pre_a2f: got %b want 0100", a2f); end
    se = 1'b1;
    for (int i = ChainLen - 1; i >= 0; i--) begin
      sc_in = cfg_mix[i];
      step();
      n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL hold_a2f bit %0d: got %b want 0100", i, a2f); end
      n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL hold_edge bit %0d: got %b want 0000", i, edge_s); end
    end
    se = 1'b0;
    sc_in = 1'b0;
    n_cmp++; if (a2f !== 4'b0100) begin n_fail++; $display("FAIL hold_fall_a2f: got %b want 0100", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL hold_fall_edge: got %b want 0000", edge_s); end
    step();
    n_cmp++; if (a2f !== 4'b0110) begin n_fail++; $display("FAIL reload_a2f: got %b want 0110", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL reload_edge: got %b want 0000", edge_s); end
    step();
    n_cmp++; if (a2f !== 4'b0110) begin n_fail++; $display("FAIL reload_after_a2f: got %b want 0110", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL reload_after_edge: got %b want 0000", edge_s); end
  endtask

  task automatic test_reset_mid();
    pad[1] = 1'b0;
    repeat (3) step();
    n_cmp++; if (a2f !== 4'b0110) begin n_fail++; $display("FAIL mid_count_a2f: got %b want 0110", a2f); end
    se = 1'b1;
    sc_in = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a2f !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_a2f: got %b want 0000", a2f); end
    n_cmp++; if (edge_s !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_edge: got %b want 0000", edge_s); end
    n_cmp++; if (sc_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sc_out: got %b want 0", sc_out); end
    n_cmp++; if (mode_o !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_mode_o: got %b want 1111", mode_o); end
    step();
    se = 1'b0;
    sc_in = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++; if (a2f !== 4'b0000) begin n_fail++; $display("FAIL mid_rel_a2f: got %b want 0000", a2f); end
    n_cmp++; if (mode_o !== 4'b1111) begin n_fail++; $display("FAIL mid_rel_mode_o: got %b want 1111", mode_o); end
    se = 1'b1;
    for (int i = 0; i < ChainLen; i++) begin
      n_cmp++; if (sc_out !== 1'b0) begin n_fail++; $display("FAIL readback bit %0d: got %b want 0", i, sc_out); end
      step();
    end
    se = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_ones();
    test_sync();
    test_filter();
    test_bypass();
    test_se_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
